if_id_buffer: RTL and testbench

- Decoupling pipeline register between the program-counter/instruction-fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Captures {pc, instruction} pairs from fetch into a 2-entry skid buffer and presents them to decode with a valid/ready handshake.
- Supports a branch/jump flush and computes pc+4 for decode (link address, branch base).
- Lets fetch keep issuing for one cycle after decode stalls without losing an instruction.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/if_id_entry_reg.sv | 26 ++
 rtl/if_id_buffer.sv | 126 ++++++++++++
 tb/tb_if_id_buffer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the IF/ID boundary of the 5-stage MIPS pipeline.
package pipeline_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RESET_PC  = 32'd100;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy doubles as the buffer state encoding.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/if_id_entry_reg.sv
// One {pc, instruction} slot of the IF/ID skid buffer.
module if_id_entry_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RST_PC    = '0,
    parameter logic [DATA_W-1:0] RST_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] instr_d,
    output logic [DATA_W-1:0] pc_q,
    output logic [DATA_W-1:0] instr_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RST_PC;
            instr_q <= RST_INSTR;
        end else if (load) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling register: 2-entry skid buffer with flush and pc+4.
module if_id_buffer #(
    parameter int                DATA_W    = pipeline_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [DATA_W-1:0] out_instr,
    output logic [1:0]        occupancy
);

    import pipeline_pkg::*;

    logic [1:0]        occ_q, occ_d;
    logic              push, pop;
    logic              head_ld, skid_ld;
    logic [DATA_W-1:0] head_pc_d, head_instr_d;
    logic [DATA_W-1:0] skid_pc_d, skid_instr_d;
    logic [DATA_W-1:0] head_pc_q, head_instr_q;
    logic [DATA_W-1:0] skid_pc_q, skid_instr_q;

    // Ready depends on registered state only, never on out_ready.
    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        occ_d        = occ_q;
        head_ld      = 1'b0;
        skid_ld      = 1'b0;
        head_pc_d    = in_pc;
        head_instr_d = in_instr;
        skid_pc_d    = in_pc;
        skid_instr_d = in_instr;
        if (flush) begin
            occ_d        = EMPTY;
            head_ld      = 1'b1;
            skid_ld      = 1'b1;
            head_pc_d    = head_pc_q;
            head_instr_d = NOP_INSTR;
            skid_pc_d    = head_pc_q;
            skid_instr_d = NOP_INSTR;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (push) begin
                        occ_d   = ONE;
                        head_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_ld = 1'b1;
                    end else if (push) begin
                        occ_d   = FULL;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        occ_d   = EMPTY;
                    end
                end
                default: begin
                    // Skid entry advances to head on a pop.
                    if (pop) begin
                        occ_d        = ONE;
                        head_ld      = 1'b1;
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    if_id_entry_reg #(
        .DATA_W    (DATA_W),
        .RST_PC    (RESET_PC),
        .RST_INSTR (NOP_INSTR)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (head_ld),
        .pc_d    (head_pc_d),
        .instr_d (head_instr_d),
        .pc_q    (head_pc_q),
        .instr_q (head_instr_q)
    );

    if_id_entry_reg #(
        .DATA_W    (DATA_W),
        .RST_PC    (RESET_PC),
        .RST_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_ld),
        .pc_d    (skid_pc_d),
        .instr_d (skid_instr_d),
        .pc_q    (skid_pc_q),
        .instr_q (skid_instr_q)
    );

    assign out_pc       = head_pc_q;
    assign out_instr    = head_instr_q;
    assign out_pc_plus4 = head_pc_q + DATA_W'(4);
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for the IF/ID skid buffer.
module tb_if_id_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    if_id_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag,
                             input logic [1:0] occ,
                             input logic [31:0] pc,
                             input logic [31:0] instr);
        chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
        chk({tag, ".ovalid"}, 32'(out_valid), 32'(occ != 2'd0));
        chk({tag, ".iready"}, 32'(in_ready), 32'(occ != 2'd2));
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".pc4"}, out_pc_plus4, pc + 32'd4);
        chk({tag, ".instr"}, out_instr, instr);
    endtask

    // Structural invariants checked every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (occupancy <= 2'd2) else begin
                errors++;
                $error("FAIL occ_range observed=%0d expected<=2",
                       occupancy);
            end
            checks++;
            assert (!(in_valid && in_ready && occupancy == 2'd2))
            else begin
                errors++;
                $error("FAIL push_full observed=1 expected=0");
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy,
                         input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("reset", 2'd0, 32'd100, 32'h0);
        rst = 1'b0;

        // Streaming with decode always ready
        drive(1'b1, 32'd100, 32'h2008_0005, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("stream0", 2'd1, 32'd100, 32'h2008_0005);
        drive(1'b1, 32'd104, 32'h2009_0003, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("stream1", 2'd1, 32'd104, 32'h2009_0003);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("drain", 2'd0, 32'd104, 32'h2009_0003);

        // Stall fill then release
        drive(1'b1, 32'd108, 32'hAAAA_0001, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("fill0", 2'd1, 32'd108, 32'hAAAA_0001);
        drive(1'b1, 32'd112, 32'hBBBB_0002, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("fill1", 2'd2, 32'd108, 32'hAAAA_0001);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("pop0", 2'd1, 32'd112, 32'hBBBB_0002);
        @(negedge clk);
        chk_state("pop1", 2'd0, 32'd112, 32'hBBBB_0002);

        // Simultaneous push and pop at ONE
        drive(1'b1, 32'd116, 32'hCCCC_0003, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("one0", 2'd1, 32'd116, 32'hCCCC_0003);
        drive(1'b1, 32'd120, 32'hDDDD_0004, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("pushpop", 2'd1, 32'd120, 32'hDDDD_0004);

        // Flush from FULL with a push offered
        drive(1'b1, 32'd124, 32'hEEEE_0005, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("full", 2'd2, 32'd120, 32'hDDDD_0004);
        drive(1'b1, 32'd200, 32'h1111_0006, 1'b1, 1'b1);
        @(negedge clk);
        chk_state("flush_full", 2'd0, 32'd120, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("post_flush", 2'd0, 32'd120, 32'h0);

        // Flush at ONE with an accepted push discards the new entry
        drive(1'b1, 32'd300, 32'h2222_0007, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("one1", 2'd1, 32'd300, 32'h2222_0007);
        drive(1'b1, 32'd304, 32'h3333_0008, 1'b1, 1'b1);
        @(negedge clk);
        chk_state("flush_one", 2'd0, 32'd300, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_state("no_ghost", 2'd0, 32'd300, 32'h0);

        // pc+4 wraps modulo 2^32
        drive(1'b1, 32'hFFFF_FFFC, 32'h4444_0009, 1'b1, 1'b0);
        @(negedge clk);
        chk("wrap.pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", out_pc_plus4, 32'h0000_0000);

        // Asynchronous reset in the middle of a cycle with FULL
        drive(1'b1, 32'd400, 32'h5555_000A, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd404, 32'h6666_000B, 1'b0, 1'b0);
        @(negedge clk);
        chk("prerst.occ", 32'(occupancy), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk_state("midrst", 2'd0, 32'd100, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("after_rst", 2'd0, 32'd100, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
